// File: rtl/pwm_multichannel_if.sv
// Control/output bundle for pwm_multichannel.
// Optional PWM_POLARITY_EN adds a live per-channel polarity input.
interface pwm_multichannel_if #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned PRESC_WIDTH = 15
);
  logic                            enable;
  logic [PRESC_WIDTH-1:0]          prescale;
  logic [WIDTH-1:0]                period;
  logic                            center_mode;
  logic [CHANNELS*(WIDTH+1)-1:0]   duty;
  logic                            duty_wr;
  logic [CHANNELS-1:0]             pwm_out;
  logic                            period_start;
`ifdef PWM_POLARITY_EN
  logic [CHANNELS-1:0]             polarity;
`endif

  modport master (
`ifdef PWM_POLARITY_EN
    output polarity,
`endif
    output enable, prescale, period, center_mode, duty, duty_wr,
    input  pwm_out, period_start
  );

  modport slave (
`ifdef PWM_POLARITY_EN
    input  polarity,
`endif
    input  enable, prescale, period, center_mode, duty, duty_wr,
    output pwm_out, period_start
  );
endinterface

// File: rtl/pwm_multichannel.sv
// Multichannel PWM: shared prescaler and period counter, per-channel duty compare, edge or
// center aligned, double-buffered config. Optional macro PWM_POLARITY_EN adds output polarity.
module pwm_multichannel #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned PRESC_WIDTH = 15
) (
  input logic               clk,
  input logic               rst_n,
  pwm_multichannel_if.slave bus
);

  localparam int unsigned DW = WIDTH + 1;
  localparam logic DirUp   = 1'b0;
  localparam logic DirDown = 1'b1;

  logic [PRESC_WIDTH-1:0]  presc_cnt_q, presc_cnt_d;
  logic [WIDTH-1:0]        cnt_q, cnt_d;
  logic                    dir_q, dir_d;
  logic [CHANNELS*DW-1:0]  pend_duty_q, pend_duty_d;
  logic [WIDTH-1:0]        pend_period_q, pend_period_d;
  logic                    pend_center_q, pend_center_d;
  logic [CHANNELS*DW-1:0]  act_duty_q, act_duty_d;
  logic [WIDTH-1:0]        act_period_q, act_period_d;
  logic                    act_center_q, act_center_d;
  logic [CHANNELS-1:0]     cmp_q, cmp_d;
  logic                    period_start_q, period_start_d;

  logic             tick;
  logic             boundary;
  logic [WIDTH-1:0] cnt_next;
  logic             dir_next;

  always_comb begin
    presc_cnt_d    = presc_cnt_q;
    cnt_d          = cnt_q;
    dir_d          = dir_q;
    act_duty_d     = act_duty_q;
    act_period_d   = act_period_q;
    act_center_d   = act_center_q;
    cmp_d          = cmp_q;
    period_start_d = 1'b0;
    tick           = 1'b0;
    boundary       = 1'b0;
    cnt_next       = cnt_q;
    dir_next       = dir_q;

    pend_duty_d   = bus.duty_wr ? bus.duty        : pend_duty_q;
    pend_period_d = bus.duty_wr ? bus.period      : pend_period_q;
    pend_center_d = bus.duty_wr ? bus.center_mode : pend_center_q;

    if (!bus.enable) begin
      presc_cnt_d  = '0;
      cnt_d        = '0;
      dir_d        = DirUp;
      cmp_d        = '0;
      act_duty_d   = pend_duty_q;
      act_period_d = pend_period_q;
      act_center_d = pend_center_q;
    end else begin
      // >= so that lowering prescale below the running count still yields a tick
      tick        = (presc_cnt_q >= bus.prescale);
      presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_WIDTH'(1);

      if (tick) begin
        if (!act_center_q) begin
          cnt_next = (cnt_q >= act_period_q) ? '0 : cnt_q + WIDTH'(1);
          dir_next = DirUp;
        end else if (dir_q == DirUp) begin
          if (cnt_q >= act_period_q) begin
            dir_next = DirDown;
            cnt_next = (act_period_q == '0) ? '0 : act_period_q - WIDTH'(1);
          end else begin
            cnt_next = cnt_q + WIDTH'(1);
          end
        end else begin
          cnt_next = cnt_q - WIDTH'(1);
        end

        boundary = (cnt_next == '0);

        // Compare uses the pre-update count and the duty active during that count
        for (int i = 0; i < CHANNELS; i++) begin
          cmp_d[i] = ({1'b0, cnt_q} < act_duty_q[i*DW +: DW]);
        end

        cnt_d = cnt_next;
        dir_d = dir_next;
        if (boundary) begin
          dir_d        = DirUp;
          act_duty_d   = pend_duty_q;
          act_period_d = pend_period_q;
          act_center_d = pend_center_q;
        end
      end
      period_start_d = tick && boundary;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_cnt_q    <= '0;
      cnt_q          <= '0;
      dir_q          <= DirUp;
      pend_duty_q    <= '0;
      pend_period_q  <= '0;
      pend_center_q  <= 1'b0;
      act_duty_q     <= '0;
      act_period_q   <= '0;
      act_center_q   <= 1'b0;
      cmp_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      presc_cnt_q    <= presc_cnt_d;
      cnt_q          <= cnt_d;
      dir_q          <= dir_d;
      pend_duty_q    <= pend_duty_d;
      pend_period_q  <= pend_period_d;
      pend_center_q  <= pend_center_d;
      act_duty_q     <= act_duty_d;
      act_period_q   <= act_period_d;
      act_center_q   <= act_center_d;
      cmp_q          <= cmp_d;
      period_start_q <= period_start_d;
    end
  end

`ifdef PWM_POLARITY_EN
  // Idle compare is 0, so reset/disable present the inactive level
  assign bus.pwm_out = cmp_q ^ bus.polarity;
`else
  assign bus.pwm_out = cmp_q;
`endif
  assign bus.period_start = period_start_q;

endmodule
